mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, memory word-address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 Parameter STARVE_LIMIT, default 4, max consecutive read grants while a write waits.
REQ-004 Clock is `clock`; one clock domain, all logic on its rising edge.
REQ-005 Reset is `reset`: synchronous, active-high.
REQ-006 Port list, one per line (name, direction, width, meaning):
clock  in  1  system clock
reset  in  1  sync active-high reset
rd_req  in  1  read request from cache-side receiver, held until rd_gnt
rd_addr  in  ADDR_W  read word address
rd_gnt  out  1  one-cycle pulse, read request accepted
wr_req  in  1  write-back request from buffer-side receiver, held until wr_gnt
wr_addr  in  ADDR_W  write word address
wr_data  in  DATA_W  write data
wr_gnt  out  1  one-cycle pulse, write accepted
mem_en  out  1  memory port access strobe
mem_we  out  1  1 = write, 0 = read (valid with mem_en)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after read strobe
rsp_valid  out  1  read response valid toward return-path sender
rsp_addr  out  ADDR_W  address of returned word
rsp_data  out  DATA_W  returned word
rsp_ready  in  1  return-path sender accepts response
busy  out  1  FSM not in IDLE

Function
REQ-007 FSM states: IDLE, RD_ISSUE, RD_CAPT, RSP, WR_ISSUE.
REQ-008 IDLE, no request: stay; all strobes low.
REQ-009 IDLE arbitration (same cycle, combinational on registered state): default read priority.
REQ-010 Hazard: rd_req and wr_req both high with rd_addr == wr_addr -> write granted first.
REQ-011 Starvation: wr_req high and starve_cnt == STARVE_LIMIT -> write granted regardless of rd_req.
REQ-012 Grant cycle: gnt pulse high exactly one cycle in IDLE; addr/data latched into internal registers same edge.
REQ-013 Read path: IDLE -> RD_ISSUE (mem_en=1, mem_we=0, mem_addr=latched addr, 1 cycle) -> RD_CAPT (capture mem_rdata) -> RSP.
REQ-014 RSP: rsp_valid=1, rsp_addr/rsp_data stable until cycle with rsp_ready=1; then -> IDLE next cycle.
REQ-015 rsp_ready high while not in RSP is ignored.
REQ-016 Write path: IDLE -> WR_ISSUE (mem_en=1, mem_we=1, addr/wdata latched, 1 cycle) -> IDLE.
REQ-017 Minimum latency: rd_gnt at cycle T, rsp_valid at T+3; wr_gnt at T, memory write strobe at T+1.
REQ-018 starve_cnt (width ceil(log2(STARVE_LIMIT+1))): +1 on read grant while wr_req high, saturates at STARVE_LIMIT; cleared on any write grant or when wr_req low in IDLE.
REQ-019 No new grant while FSM not in IDLE; requests wait, no loss.
REQ-020 mem_en never asserted in IDLE, RD_CAPT, RSP.
REQ-021 busy = (state != IDLE).

Reset
REQ-022 reset high at a clock edge -> state IDLE, starve_cnt 0, latched addr/data 0, regardless of current state (incl. mid-RSP).
REQ-023 Outputs during/after reset: rd_gnt, wr_gnt, mem_en, mem_we, rsp_valid, busy = 0; mem_addr, mem_wdata, rsp_addr, rsp_data = 0.
REQ-024 An in-flight read/write aborted by reset is dropped; requester re-requests.

Configuration
REQ-025 Macro MEM_ARB_STARVE_EN: defined -> REQ-011/REQ-018 active; undefined -> starve_cnt absent, strict read priority except REQ-010 hazard rule.

Verification
REQ-026 rd_req, rd_addr=0x005, mem word 0x005=0xDEADBEEF, rsp_ready=1 -> rd_gnt T, mem read strobe T+1, rsp_valid T+3 with rsp_data 0xDEADBEEF, rsp_addr 0x005.
REQ-027 wr_req addr 0x3FF data 0x12345678 alone -> wr_gnt T, mem_en=1 mem_we=1 addr 0x3FF wdata 0x12345678 at T+1, busy low T+2.
REQ-028 rd_req and wr_req both addr 0x010 -> wr_gnt first; following read returns written value.
REQ-029 MEM_ARB_STARVE_EN defined, STARVE_LIMIT=4, rd_req continuous (distinct addrs), wr_req high -> exactly 4 read grants then wr_gnt; undefined -> wr_gnt only after rd_req drops.
REQ-030 rsp_ready low 5 cycles in RSP -> rsp_valid/rsp_data stable 5 cycles, no grant, no mem_en; transfer on first ready cycle.
REQ-031 reset asserted in RD_CAPT -> next cycle all outputs 0, state IDLE, no rsp_valid for aborted read.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the cache/write-back requesters, the memory port and the
// read-return path of mem_arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ready;
  logic              busy;

  // The arbiter side.
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata, rsp_ready,
    output rd_gnt, wr_gnt, mem_en, mem_we, mem_addr, mem_wdata,
           rsp_valid, rsp_addr, rsp_data, busy
  );

  // Requesters, memory and return path seen together from outside.
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata, rsp_ready,
    input  rd_gnt, wr_gnt, mem_en, mem_we, mem_addr, mem_wdata,
           rsp_valid, rsp_addr, rsp_data, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: read priority, same-address write-first hazard rule.
// Optional write anti-starvation counter enabled by defining MEM_ARB_STARVE_EN.
module mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAPT  = 3'd2,
    RSP      = 3'd3,
    WR_ISSUE = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;

  logic rd_gnt_c, wr_gnt_c;
  logic mem_en_c, mem_we_c, rsp_valid_c;
  logic hazard, starve_hit, pick_wr;

  // A same-address pair must see the write land before the read samples memory.
  assign hazard  = bus.rd_req && bus.wr_req && (bus.rd_addr == bus.wr_addr);
  assign pick_wr = bus.wr_req && (!bus.rd_req || hazard || starve_hit);

`ifdef MEM_ARB_STARVE_EN
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

  assign starve_hit = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (state_reg == IDLE) begin
      if (wr_gnt_c || !bus.wr_req) begin
        starve_cnt_next = '0;
      end else if (rd_gnt_c && !starve_hit) begin
        starve_cnt_next = starve_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`else
  logic unused_starve_limit;

  assign starve_hit          = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    rd_gnt_c    = 1'b0;
    wr_gnt_c    = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    rsp_valid_c = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_wr) begin
          wr_gnt_c   = 1'b1;
          addr_next  = bus.wr_addr;
          wdata_next = bus.wr_data;
          state_next = WR_ISSUE;
        end else if (bus.rd_req) begin
          rd_gnt_c   = 1'b1;
          addr_next  = bus.rd_addr;
          state_next = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        mem_en_c   = 1'b1;
        state_next = RD_CAPT;
      end
      RD_CAPT: begin
        rdata_next = bus.mem_rdata;
        state_next = RSP;
      end
      RSP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      WR_ISSUE: begin
        mem_en_c   = 1'b1;
        mem_we_c   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is high, whatever state is still registered.
  assign bus.rd_gnt    = rd_gnt_c    & ~reset;
  assign bus.wr_gnt    = wr_gnt_c    & ~reset;
  assign bus.mem_en    = mem_en_c    & ~reset;
  assign bus.mem_we    = mem_we_c    & ~reset;
  assign bus.rsp_valid = rsp_valid_c & ~reset;
  assign bus.busy      = (state_reg != IDLE) & ~reset;
  assign bus.mem_addr  = reset ? '0 : addr_reg;
  assign bus.mem_wdata = reset ? '0 : wdata_reg;
  assign bus.rsp_addr  = reset ? '0 : addr_reg;
  assign bus.rsp_data  = reset ? '0 : rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
`ifdef MEM_ARB_STARVE_EN
  localparam int EXP_READS_BEFORE_WR = 4;
`else
  localparam int EXP_READS_BEFORE_WR = 6;
`endif

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  function automatic logic [DATA_W-1:0] init_word(input int a);
    logic [DATA_W-1:0] w;
    w = 32'hC0DE_0000 | a;
    if (a == 5) w = 32'hDEAD_BEEF;
    return w;
  endfunction

  // Memory: read data appears the cycle after the strobe; reset reloads contents.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= init_word(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  reads;
    bit  got_wr;
    bit  saw_rd;

    reset         = 1'b1;
    bus.rd_req    = 1'b1;
    bus.rd_addr   = 10'h005;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rsp_ready = 1'b1;
    bus.mem_rdata = '0;

    // Reset state, with a read request held to prove grants are masked.
    step(); step(); #1;
    check_eq("rst rd_gnt",    bus.rd_gnt,    0);
    check_eq("rst busy",      bus.busy,      0);
    check_eq("rst mem_en",    bus.mem_en,    0);
    check_eq("rst rsp_valid", bus.rsp_valid, 0);
    check_eq("rst mem_addr",  bus.mem_addr,  0);
    check_eq("rst rsp_data",  bus.rsp_data,  0);
    bus.rd_req = 1'b0;
    reset      = 1'b0;

    // Single read of 0x005.
    step();
    bus.rd_req  = 1'b1;
    bus.rd_addr = 10'h005;
    #1;
    check_eq("rd T rd_gnt", bus.rd_gnt, 1);
    check_eq("rd T busy",   bus.busy,   0);
    step(); bus.rd_req = 1'b0; #1;
    check_eq("rd T+1 mem_en",   bus.mem_en,   1);
    check_eq("rd T+1 mem_we",   bus.mem_we,   0);
    check_eq("rd T+1 mem_addr", bus.mem_addr, 32'h005);
    step(); #1;
    check_eq("rd T+2 mem_en",    bus.mem_en,    0);
    check_eq("rd T+2 rsp_valid", bus.rsp_valid, 0);
    step(); #1;
    check_eq("rd T+3 rsp_valid", bus.rsp_valid, 1);
    check_eq("rd T+3 rsp_data",  bus.rsp_data,  32'hDEAD_BEEF);
    check_eq("rd T+3 rsp_addr",  bus.rsp_addr,  32'h005);
    step(); #1;
    check_eq("rd T+4 busy", bus.busy, 0);

    // Single write to 0x3FF.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 10'h3FF;
    bus.wr_data = 32'h1234_5678;
    #1;
    check_eq("wr T wr_gnt", bus.wr_gnt, 1);
    check_eq("wr T rd_gnt", bus.rd_gnt, 0);
    step(); bus.wr_req = 1'b0; #1;
    check_eq("wr T+1 mem_en",    bus.mem_en,    1);
    check_eq("wr T+1 mem_we",    bus.mem_we,    1);
    check_eq("wr T+1 mem_addr",  bus.mem_addr,  32'h3FF);
    check_eq("wr T+1 mem_wdata", bus.mem_wdata, 32'h1234_5678);
    check_eq("wr T+1 busy",      bus.busy,      1);
    step(); #1;
    check_eq("wr T+2 busy", bus.busy, 0);
    check_eq("wr mem[3FF]", mem[10'h3FF], 32'h1234_5678);

    // Same-address hazard: write wins, read then returns the written word.
    bus.rd_req  = 1'b1; bus.rd_addr = 10'h010;
    bus.wr_req  = 1'b1; bus.wr_addr = 10'h010; bus.wr_data = 32'hCAFE_F00D;
    #1;
    check_eq("haz wr_gnt", bus.wr_gnt, 1);
    check_eq("haz rd_gnt", bus.rd_gnt, 0);
    step(); bus.wr_req = 1'b0; #1;
    check_eq("haz WR_ISSUE rd_gnt", bus.rd_gnt, 0);
    step(); #1;
    check_eq("haz rd_gnt after wr", bus.rd_gnt, 1);
    step(); bus.rd_req = 1'b0; step(); step(); #1;
    check_eq("haz rsp_data", bus.rsp_data, 32'hCAFE_F00D);
    check_eq("haz rsp_addr", bus.rsp_addr, 32'h010);
    step(); #1;

    // Different addresses: read wins, write follows when the read completes.
    bus.rd_req  = 1'b1; bus.rd_addr = 10'h020;
    bus.wr_req  = 1'b1; bus.wr_addr = 10'h021; bus.wr_data = 32'h0000_0021;
    #1;
    check_eq("prio rd_gnt", bus.rd_gnt, 1);
    check_eq("prio wr_gnt", bus.wr_gnt, 0);
    step(); bus.rd_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check_eq($sformatf("prio T+%0d wr_gnt", c), bus.wr_gnt, 0);
      step();
    end
    #1;
    check_eq("prio T+4 wr_gnt", bus.wr_gnt, 1);
    step(); bus.wr_req = 1'b0; step(); #1;

    // Response back-pressure: 5 cycles with rsp_ready low, write waiting.
    bus.rsp_ready = 1'b0;
    bus.rd_req    = 1'b1; bus.rd_addr = 10'h005;
    #1;
    check_eq("bp rd_gnt", bus.rd_gnt, 1);
    step(); bus.rd_req = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = 10'h006; bus.wr_data = 32'h0000_0666;
    step(); step(); #1;
    for (int c = 0; c < 5; c++) begin
      check_eq($sformatf("bp%0d rsp_valid", c), bus.rsp_valid, 1);
      check_eq($sformatf("bp%0d rsp_data", c),  bus.rsp_data,  32'hDEAD_BEEF);
      check_eq($sformatf("bp%0d wr_gnt", c),    bus.wr_gnt,    0);
      check_eq($sformatf("bp%0d mem_en", c),    bus.mem_en,    0);
      step(); #1;
    end
    bus.rsp_ready = 1'b1; #1;
    check_eq("bp ready rsp_valid", bus.rsp_valid, 1);
    check_eq("bp ready wr_gnt",    bus.wr_gnt,    0);
    step(); #1;
    check_eq("bp after wr_gnt", bus.wr_gnt, 1);
    step(); bus.wr_req = 1'b0; step(); #1;

    // Continuous reads with a write waiting.
    reads  = 0;
    got_wr = 1'b0;
    bus.wr_req  = 1'b1; bus.wr_addr = 10'h100; bus.wr_data = 32'h0000_0055;
    bus.rd_req  = 1'b1; bus.rd_addr = 10'h200;
    for (int c = 0; c < 80 && !got_wr; c++) begin
      #1;
      saw_rd = bus.rd_gnt;
      if (bus.wr_gnt) got_wr = 1'b1;
      else if (bus.rd_gnt) reads++;
      step();
      if (saw_rd) begin
        bus.rd_addr = bus.rd_addr + 10'd1;
        if (reads == 6) bus.rd_req = 1'b0;
      end
      if (got_wr) begin
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
      end
    end
    check_eq("starve wr_gnt seen",     got_wr, 1);
    check_eq("starve reads before wr", reads,  EXP_READS_BEFORE_WR);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    for (int c = 0; c < 6; c++) step();
    #1;
    check_eq("starve idle after", bus.busy, 0);

    // Reset while a read sits in RD_CAPT.
    bus.rd_req = 1'b1; bus.rd_addr = 10'h005;
    #1;
    check_eq("abort rd_gnt", bus.rd_gnt, 1);
    step(); bus.rd_req = 1'b0;
    step(); reset = 1'b1; #1;
    check_eq("abort in-rst busy",   bus.busy,   0);
    check_eq("abort in-rst mem_en", bus.mem_en, 0);
    step(); reset = 1'b0; #1;
    check_eq("abort busy",     bus.busy,     0);
    check_eq("abort rsp_addr", bus.rsp_addr, 0);
    check_eq("abort rsp_data", bus.rsp_data, 0);
    check_eq("abort mem_addr", bus.mem_addr, 0);
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("abort +%0d rsp_valid", c), bus.rsp_valid, 0);
      step(); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
